pri_encoder_irq: RTL and testbench

- Parametrised, registered priority encoder with request latching.
- Successor to the combinational 8-3 priority encoder; generalised to N request lines.
- Adds a level or edge capture mode, a sticky pending register, and a valid/ready output handshake.
- Sits between raw request/interrupt sources and a consumer (CPU or sequencer), which acknowledges each encoded code in turn.

---
 rtl/pri_encoder_irq.sv | 103 ++++++++++
 tb/tb_pri_encoder_irq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pri_encoder_irq.sv
// Registered N-line priority encoder with request latching and valid/ready output.
// Optional request mask enabled by defining PRI_ENC_MASK_EN.
module pri_encoder_irq #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int EDGE = 0
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic [N-1:0] iData,
    input  logic         iEI,
    input  logic         iReady,
`ifdef PRI_ENC_MASK_EN
    input  logic         iMaskWe,
    input  logic [N-1:0] iMaskData,
`endif
    output logic [W-1:0] oData,
    output logic         oValid,
    output logic         oEO,
    output logic [N-1:0] oPending
);

    logic [N-1:0] pend;
    logic [N-1:0] prev;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic [N-1:0] pend_nxt;
    logic [N-1:0] avail;
    logic [N-1:0] vis;
    logic [W-1:0] top_idx;
    logic         xfer;
    logic         free;

    // Ascending scan so the highest set bit wins.
    function automatic logic [W-1:0] top_index(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

`ifdef PRI_ENC_MASK_EN
    logic [N-1:0] mask;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            mask <= '1;
        end else if (iMaskWe) begin
            mask <= iMaskData;
        end
    end

    assign vis = mask;
`else
    assign vis = '1;
`endif

    assign xfer = oValid & iReady;
    assign free = ~oValid | xfer;

    always_comb begin
        set_vec = '0;
        if (!iEI) begin
            set_vec = (EDGE != 0) ? (iData & ~prev) : iData;
        end
    end

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N; i++) begin
            clr_vec[i] = xfer && (oData == W'(i));
        end
    end

    // Set wins over clear on the same bit.
    assign pend_nxt = (pend & ~clr_vec) | set_vec;
    assign avail    = pend_nxt & vis;
    assign top_idx  = top_index(avail);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pend   <= '0;
            prev   <= '0;
            oData  <= '0;
            oValid <= 1'b0;
        end else begin
            pend <= pend_nxt;
            prev <= iData;
            if (free) begin
                oValid <= |avail;
                if (|avail) begin
                    oData <= top_idx;
                end
            end
        end
    end

    assign oEO      = ~iEI & ~|(pend & vis) & ~oValid;
    assign oPending = pend;

endmodule

// File: tb/tb_pri_encoder_irq.sv
// Directed and random bench for pri_encoder_irq, level and edge instances
// driven in parallel and checked against a vector-level reference model.
module tb_pri_encoder_irq;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ei = 1'b0;
    logic         rdy = 1'b0;
    logic [N-1:0] d = '0;
`ifdef PRI_ENC_MASK_EN
    logic         mwe = 1'b0;
    logic [N-1:0] mdat = '1;
`endif

    logic [W-1:0] dl, de;
    logic         vl, ve, eol, eoe;
    logic [N-1:0] pl, pe;

    int checks = 0;
    int errors = 0;
    int lcnt, ecnt;

    logic [N-1:0] m_pend [2];
    logic [W-1:0] m_data [2];
    logic         m_valid[2];
    logic [N-1:0] m_prev;
    logic [N-1:0] m_mask;

    always #5 clk = ~clk;

    pri_encoder_irq #(.N(N), .EDGE(0)) u_lvl (
        .iClk(clk), .iRst_n(rst_n), .iData(d), .iEI(ei), .iReady(rdy),
`ifdef PRI_ENC_MASK_EN
        .iMaskWe(mwe), .iMaskData(mdat),
`endif
        .oData(dl), .oValid(vl), .oEO(eol), .oPending(pl)
    );

    pri_encoder_irq #(.N(N), .EDGE(1)) u_edg (
        .iClk(clk), .iRst_n(rst_n), .iData(d), .iEI(ei), .iReady(rdy),
`ifdef PRI_ENC_MASK_EN
        .iMaskWe(mwe), .iMaskData(mdat),
`endif
        .oData(de), .oValid(ve), .oEO(eoe), .oPending(pe)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            m_pend[e]  = '0;
            m_data[e]  = '0;
            m_valid[e] = 1'b0;
        end
        m_prev = '0;
        m_mask = '1;
    endtask

    // One clock edge of the reference: requests captured, the presented
    // code retired on acceptance, highest available request shown next.
    task automatic model_edge();
        logic [N-1:0] set, clr, nxt, avail;
        for (int e = 0; e < 2; e++) begin
            set = ei ? '0 : ((e == 1) ? (d & ~m_prev) : d);
            clr = (m_valid[e] && rdy) ? (N'(1) << m_data[e]) : '0;
            nxt = (m_pend[e] & ~clr) | set;
            avail = nxt & m_mask;
            if (!m_valid[e] || rdy) begin
                m_valid[e] = (avail != 0);
                if (avail != 0)
                    m_data[e] = W'($clog2(int'(avail) + 1) - 1);
            end
            m_pend[e] = nxt;
        end
        m_prev = d;
`ifdef PRI_ENC_MASK_EN
        if (mwe) m_mask = mdat;
`endif
    endtask

    task automatic cmp_all(input string tag);
        logic eo0, eo1;
        eo0 = !ei && ((m_pend[0] & m_mask) == 0) && !m_valid[0];
        eo1 = !ei && ((m_pend[1] & m_mask) == 0) && !m_valid[1];
        chk({tag, ".lvl.valid"}, 64'(vl), 64'(m_valid[0]));
        chk({tag, ".lvl.pend"}, 64'(pl), 64'(m_pend[0]));
        chk({tag, ".lvl.eo"}, 64'(eol), 64'(eo0));
        chk({tag, ".edg.valid"}, 64'(ve), 64'(m_valid[1]));
        chk({tag, ".edg.pend"}, 64'(pe), 64'(m_pend[1]));
        chk({tag, ".edg.eo"}, 64'(eoe), 64'(eo1));
        if (m_valid[0]) chk({tag, ".lvl.data"}, 64'(dl), 64'(m_data[0]));
        if (m_valid[1]) chk({tag, ".edg.data"}, 64'(de), 64'(m_data[1]));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        cmp_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_all("reset");
        chk("reset.data", 64'(dl), 64'(0));
        chk("reset.eo", 64'(eol), 64'(1));
        rst_n = 1'b1;
        step("idle");

        rdy = 1'b1;
        d = 8'hA4;
        step("prio0");
        chk("prio.code7", 64'(dl), 64'(7));
        d = '0;
        step("prio1");
        chk("prio.code5", 64'(dl), 64'(5));
        step("prio2");
        chk("prio.code2", 64'(dl), 64'(2));
        step("prio3");
        chk("prio.empty", 64'(vl), 64'(0));
        chk("prio.eo", 64'(eol), 64'(1));

        rdy = 1'b0;
        d = 8'h04;
        step("bp0");
        d = '0;
        step("bp1");
        d = 8'h40;
        step("bp2");
        d = '0;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            chk("bp.hold_code", 64'(dl), 64'(2));
            chk("bp.hold_pend", 64'(pl), 64'(8'h44));
        end
        rdy = 1'b1;
        step("bp_rel");
        chk("bp.next_code", 64'(dl), 64'(6));
        step("bp_drain");
        chk("bp.drained", 64'(vl), 64'(0));

        rdy = 1'b0;
        d = 8'h08;
        step("en_pre");
        ei = 1'b1;
        d = 8'hFF;
        step("en_block");
        chk("en.pend", 64'(pl), 64'(8'h08));
        chk("en.code3", 64'(dl), 64'(3));
        chk("en.eo", 64'(eol), 64'(0));
        rdy = 1'b1;
        step("en_drain");
        chk("en.drained", 64'(vl), 64'(0));
        ei = 1'b0;
        d = '0;
        step("en_idle");

        d = 8'h10;
        lcnt = 0;
        ecnt = 0;
        for (int i = 0; i < 10; i++) begin
            step("held");
            if (vl && dl == 3'd4) lcnt++;
            if (ve && de == 3'd4) ecnt++;
        end
        chk("held.level_count", 64'(lcnt), 64'(10));
        chk("held.edge_count", 64'(ecnt), 64'(1));
        d = '0;
        step("held_end0");
        step("held_end1");

        rdy = 1'b0;
        d = 8'h81;
        step("mr0");
        d = '0;
        step("mr1");
        rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all("midrst");
        chk("midrst.data", 64'(dl), 64'(0));
        @(posedge clk);
        #1;
        cmp_all("midrst_hold");
        rst_n = 1'b1;
        step("midrst_rel");

`ifdef PRI_ENC_MASK_EN
        mwe = 1'b1;
        mdat = 8'h7F;
        step("mk0");
        mwe = 1'b0;
        d = 8'h82;
        step("mk1");
        chk("mask.code1", 64'(dl), 64'(1));
        d = '0;
        step("mk2");
        chk("mask.hidden", 64'(vl), 64'(0));
        chk("mask.pend", 64'(pl), 64'(8'h80));
        mwe = 1'b1;
        mdat = 8'hFF;
        step("mk3");
        mwe = 1'b0;
        step("mk4");
        chk("mask.code7", 64'(dl), 64'(7));
        step("mk5");
`endif

        for (int i = 0; i < 400; i++) begin
            d = N'($urandom & $urandom);
            ei = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
`ifdef PRI_ENC_MASK_EN
            mwe = ($urandom_range(0, 7) == 0);
            mdat = N'($urandom);
`endif
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
